// File: rtl/outp_deserializer.sv
// rtl/outp_deserializer.sv - serial outp/overflw sample deserializer with one-word output buffer
// Assembles WIDTH qualified samples LSB-first, flags overflow per word and counts overflow events.
module outp_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sample_en,
  input  logic             outp,
  input  logic             overflw,
  input  logic             data_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             frame_ovf,
  output logic [CNT_W-1:0] ovf_count,
  output logic             overrun
);

  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE,
    COLLECT
  } state_t;

  state_t           state_q, state_d;
  logic [BC_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_ovf_q, frame_ovf_d;
  logic [CNT_W-1:0] ovf_count_q, ovf_count_d;
  logic             overrun_q, overrun_d;

  logic             last_sample;
  logic [WIDTH-1:0] word_c;
  logic             word_ovf_c;

  always_comb begin
    last_sample = sample_en && (bit_cnt_q == LAST_BIT);
    // The completed word is the held bits plus the sample arriving this edge.
    word_c = shift_q;
    word_c[bit_cnt_q] = outp;
    word_ovf_c = acc_ovf_q | overflw;
  end

  always_comb begin
    state_d = state_q;
    if (sample_en) begin
      state_d = last_sample ? IDLE : COLLECT;
    end
  end

  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    acc_ovf_d    = acc_ovf_q;
    data_out_d   = data_out_q;
    data_valid_d = data_valid_q;
    frame_ovf_d  = frame_ovf_q;
    ovf_count_d  = ovf_count_q;
    overrun_d    = overrun_q;

    if (sample_en) begin
      if (overflw && (ovf_count_q != CNT_MAX)) begin
        ovf_count_d = ovf_count_q + CNT_W'(1);
      end
      if (last_sample) begin
        bit_cnt_d = '0;
        shift_d   = '0;
        acc_ovf_d = 1'b0;
      end else begin
        bit_cnt_d = bit_cnt_q + BC_W'(1);
        shift_d   = word_c;
        acc_ovf_d = word_ovf_c;
      end
    end

    if (last_sample) begin
      // A completed word may replace the buffered one only if it is being consumed.
      if (!data_valid_q || data_ready) begin
        data_out_d   = word_c;
        frame_ovf_d  = word_ovf_c;
        data_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (data_valid_q && data_ready) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      acc_ovf_q    <= 1'b0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      frame_ovf_q  <= 1'b0;
      ovf_count_q  <= '0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      acc_ovf_q    <= acc_ovf_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      frame_ovf_q  <= frame_ovf_d;
      ovf_count_q  <= ovf_count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign frame_ovf  = frame_ovf_q;
  assign ovf_count  = ovf_count_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_outp_deserializer.sv
// tb/tb_outp_deserializer.sv - self-checking bench for outp_deserializer
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_outp_deserializer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sample_en = 1'b0;
  logic       outp = 1'b0;
  logic       overflw = 1'b0;
  logic       data_ready = 1'b0;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_ovf;
  logic [7:0] ovf_count;
  logic       overrun;

  outp_deserializer #(.WIDTH(8), .CNT_W(8)) dut (
    .clock      (clock),
    .reset      (reset),
    .sample_en  (sample_en),
    .outp       (outp),
    .overflw    (overflw),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_ovf  (frame_ovf),
    .ovf_count  (ovf_count),
    .overrun    (overrun)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;

  bit         q_bits[$];
  bit         m_acc;
  logic [7:0] m_out;
  bit         m_valid;
  bit         m_fovf;
  bit         m_overrun;
  int         m_cnt;
  bit         in_reset;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all(input string ctx);
    check_eq({ctx, ".data_out"},   32'(data_out),   32'(m_out));
    check_eq({ctx, ".data_valid"}, 32'(data_valid), 32'(m_valid));
    check_eq({ctx, ".frame_ovf"},  32'(frame_ovf),  32'(m_fovf));
    check_eq({ctx, ".ovf_count"},  32'(ovf_count),  32'(m_cnt));
    check_eq({ctx, ".overrun"},    32'(overrun),    32'(m_overrun));
  endtask

  task automatic model_reset();
    q_bits.delete();
    m_acc = 0; m_out = '0; m_valid = 0; m_fovf = 0; m_overrun = 0; m_cnt = 0;
  endtask

  task automatic model_edge(input bit en, input bit o, input bit ov, input bit rdy);
    bit         done;
    logic [7:0] w;
    done = 0;
    if (in_reset) return;
    if (en) begin
      if (ov && m_cnt < 255) m_cnt++;
      q_bits.push_back(o);
      m_acc |= ov;
      if (q_bits.size() == 8) begin
        done = 1;
        w = '0;
        for (int k = 0; k < 8; k++) w[k] = q_bits[k];
        if (!m_valid || rdy) begin
          m_out = w; m_fovf = m_acc; m_valid = 1;
        end else begin
          m_overrun = 1;
        end
        q_bits.delete();
        m_acc = 0;
      end
    end
    if (!done && m_valid && rdy) m_valid = 0;
  endtask

  task automatic step(input bit en, input bit o, input bit ov, input bit rdy, input string ctx);
    sample_en = en; outp = o; overflw = ov; data_ready = rdy;
    @(posedge clock);
    model_edge(en, o, ov, rdy);
    #1;
    check_all(ctx);
  endtask

  task automatic send_word(input logic [7:0] w, input bit rdy_other, input bit rdy_last, input string ctx);
    for (int k = 0; k < 8; k++) step(1'b1, w[k], 1'b0, (k == 7) ? rdy_last : rdy_other, ctx);
  endtask

  task automatic pulse_reset(input int cycles);
    #2 reset = 1'b0;
    in_reset = 1;
    model_reset();
    #1 check_all("rst_async");
    for (int i = 0; i < cycles; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "rst_hold");
    reset = 1'b1;
    in_reset = 0;
  endtask

  initial begin
    logic [7:0] w8d;
    w8d = 8'h8D;
    in_reset = 1;
    model_reset();
    #1 check_all("rst_init");
    for (int i = 0; i < 4; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), "rst_hold");
    reset = 1'b1;
    in_reset = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, "post_rst");

    send_word(8'h8D, 1'b1, 1'b1, "basic");
    check_eq("basic_word", 32'(data_out), 32'h8D);
    check_eq("basic_valid", 32'(data_valid), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "basic_drain");
    check_eq("basic_one_cycle", 32'(data_valid), 32'h0);

    for (int k = 0; k < 8; k++) begin
      if (k == 4)
        for (int g = 0; g < 3; g++) step(1'b0, 1'(g), 1'b1, 1'b1, "gap_idle");
      step(1'b1, w8d[k], 1'b0, 1'b1, "gap");
    end
    check_eq("gap_word", 32'(data_out), 32'h8D);
    check_eq("gap_fovf", 32'(frame_ovf), 32'h0);

    step(1'b0, 1'b0, 1'b0, 1'b1, "ovr_pre");
    send_word(8'hA5, 1'b0, 1'b0, "ovr_a");
    send_word(8'h3C, 1'b0, 1'b0, "ovr_b");
    check_eq("ovr_word", 32'(data_out), 32'hA5);
    check_eq("ovr_valid", 32'(data_valid), 32'h1);
    check_eq("ovr_flag", 32'(overrun), 32'h1);
    step(1'b0, 1'b0, 1'b0, 1'b1, "ovr_drain");
    check_eq("ovr_drained", 32'(data_valid), 32'h0);
    check_eq("ovr_sticky", 32'(overrun), 32'h1);

    pulse_reset(1);
    check_eq("rst_clr_ovr", 32'(overrun), 32'h0);
    send_word(8'h5A, 1'b0, 1'b0, "b2b_1");
    send_word(8'hC3, 1'b0, 1'b1, "b2b_2");
    check_eq("b2b_word", 32'(data_out), 32'hC3);
    check_eq("b2b_valid", 32'(data_valid), 32'h1);
    check_eq("b2b_ovr", 32'(overrun), 32'h0);

    for (int i = 0; i < 300; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b1, "sat");
    check_eq("sat_count", 32'(ovf_count), 32'd255);
    check_eq("sat_fovf", 32'(frame_ovf), 32'h1);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, "sat_tail");
    pulse_reset(2);
    send_word(8'hFF, 1'b1, 1'b1, "after_rst");
    check_eq("after_rst_word", 32'(data_out), 32'hFF);
    check_eq("after_rst_cnt", 32'(ovf_count), 32'h0);

    for (int i = 0; i < 2400; i++) begin
      if (i % 600 == 599) pulse_reset(1);
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
